// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator; in-window byte/half stores become read-modify-write of the full word.
// respValid 1 (error), 2 (word/MMIO store), 3 (load) or 4 (RAM sub-word store) cycles after accept; reqReady only in IDLE.
module load_store_unit #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqStore,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic        memWriteEnable,
    output logic [3:0]  memWriteByteSelect,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR       = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]  state, nextState;
    logic [31:0] addrQ;
    logic [15:0] dataQ;
    logic [2:0]  funct3Q;
    logic        storeQ;

    logic        accept, reqErr, reqInWindow, reqWord;
    logic [31:0] directWord, loadValue, mergedWord, rdWord;

    function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extractLoad = {{24{b[7]}}, b};
            3'b001:  extractLoad = {{16{h[15]}}, h};
            3'b100:  extractLoad = {24'b0, b};
            3'b101:  extractLoad = {16'b0, h};
            default: extractLoad = word;
        endcase
    endfunction

    function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic half,
                                               input logic [1:0] off, input logic [15:0] data);
        logic [31:0] merged;
        merged = word;
        if (half) merged[{off[1], 4'b0000} +: 16] = data;
        else      merged[{off, 3'b000} +: 8]      = data[7:0];
        return merged;
    endfunction

    assign accept             = reqValid && reqReady;
    assign memAddress         = {addrQ[31:2], 2'b00};
    assign memWriteByteSelect = {4{memWriteEnable}};
    assign rdWord             = memDataOut;
    assign loadValue          = extractLoad(rdWord, funct3Q, addrQ[1:0]);
    assign mergedWord         = mergeStore(rdWord, funct3Q[0], addrQ[1:0], dataQ);

    // Unsigned wrap of the subtraction makes addresses below the base fall outside the window.
    always_comb begin
        reqWord     = (reqFunct3 == 3'b010);
        reqInWindow = (reqAddr - MEM_BASE) < MEM_BYTES;
        case (reqFunct3)
            3'b000:  reqErr = 1'b0;
            3'b001:  reqErr = reqAddr[0];
            3'b010:  reqErr = (reqAddr[1:0] != 2'b00);
            3'b100:  reqErr = reqStore;
            3'b101:  reqErr = reqStore | reqAddr[0];
            default: reqErr = 1'b1;
        endcase
        if (reqWord)           directWord = reqData;
        else if (reqFunct3[0]) directWord = {16'b0, reqData[15:0]};
        else                   directWord = {24'b0, reqData[7:0]};
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqErr)                       nextState = RESP;
                    else if (!reqStore)               nextState = RD_ISSUE;
                    else if (!reqWord && reqInWindow) nextState = RD_ISSUE;
                    else                              nextState = WR;
                end
            end
            RD_ISSUE: nextState = RD_WAIT;
            RD_WAIT:  nextState = storeQ ? WR : RESP;
            WR:       nextState = RESP;
            RESP:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= IDLE;
            reqReady       <= 1'b0;
            respValid      <= 1'b0;
            respError      <= 1'b0;
            respData       <= 32'b0;
            memWriteEnable <= 1'b0;
            memDataIn      <= 32'b0;
            addrQ          <= 32'b0;
            dataQ          <= 16'b0;
            funct3Q        <= 3'b0;
            storeQ         <= 1'b0;
        end else begin
            state          <= nextState;
            reqReady       <= (nextState == IDLE);
            memWriteEnable <= (nextState == WR);
            respValid      <= (nextState == RESP);
            respError      <= 1'b0;
            respData       <= 32'b0;
            if (accept) begin
                addrQ     <= reqAddr;
                dataQ     <= reqData[15:0];
                funct3Q   <= reqFunct3;
                storeQ    <= reqStore;
                respError <= reqErr;
                if (nextState == WR) memDataIn <= directWord;
            end
            if (state == RD_WAIT) begin
                if (storeQ) memDataIn <= mergedWord;
                else        respData  <= loadValue;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors, mid-access reset, then random traffic against a word-array model.
module tb_load_store_unit;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid = 1'b0, reqStore = 1'b0;
    logic [2:0]  reqFunct3 = 3'b0;
    logic [31:0] reqAddr = 32'b0, reqData = 32'b0;
    logic        reqReady, respValid, respError, memWriteEnable;
    logic [31:0] respData, memAddress, memDataIn, memDataOut;
    logic [3:0]  memWriteByteSelect;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BASE(BASE), .MEM_BYTES(4096)) dut (
        .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore),
        .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqData(reqData), .respValid(respValid),
        .respData(respData), .respError(respError), .memAddress(memAddress),
        .memWriteEnable(memWriteEnable), .memWriteByteSelect(memWriteByteSelect),
        .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    // Bus-side memory: 4 KiB RAM window plus a 64-word MMIO/outside area aliased on addr[7:2].
    logic [31:0] busRam [0:1023];
    logic [31:0] busOther [0:63];
    logic [31:0] refRam [0:1023];
    logic [31:0] refOther [0:63];
    logic        preEn = 1'b0;
    logic [10:0] preIdx = 11'b0;
    logic [31:0] preVal = 32'b0;
    int          wrTotal = 0;
    logic [31:0] busOff;
    assign busOff = memAddress - BASE;

    always @(posedge clk) begin
        if (preEn) begin
            if (preIdx < 11'd1024) busRam[preIdx[9:0]] <= preVal;
            else                   busOther[preIdx[5:0]] <= preVal;
        end else if (memWriteEnable) begin
            if (busOff < 32'd4096) busRam[busOff[11:2]] <= memDataIn;
            else                   busOther[memAddress[7:2]] <= memDataIn;
            wrTotal <= wrTotal + 1;
        end
        memDataOut <= (busOff < 32'd4096) ? busRam[busOff[11:2]] : busOther[memAddress[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refRead(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32'd4096) return refRam[off[11:2]];
        return refOther[a[7:2]];
    endfunction

    task automatic refWrite(input logic [31:0] a, input logic [31:0] v);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32'd4096) refRam[off[11:2]] = v;
        else                refOther[a[7:2]] = v;
    endtask

    // Reference: expected latency, response and write word straight from the RV32 access rules.
    task automatic modelReq(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output logic [31:0] eData,
                            output logic eErr, output logic eDoWr, output logic [31:0] eWr);
        int size, sh;
        logic [31:0] mask, w, v;
        bit legal, win;
        eData = 0; eErr = 0; eDoWr = 0; eWr = 0; lat = 0;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!legal || (int'(a[1:0]) % size) != 0) begin
            lat = 1; eErr = 1;
            return;
        end
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh = 8 * int'(a[1:0]);
        w = refRead(a);
        win = (a >= BASE) && (a < BASE + 32'd4096);
        if (!st) begin
            v = (w >> sh) & mask;
            if ((f3 == 3'd0 && v[7]) || (f3 == 3'd1 && v[15])) v = v | ~mask;
            eData = v; lat = 3;
        end else begin
            eDoWr = 1;
            if (size == 4) begin eWr = d; lat = 2; end
            else if (win) begin eWr = (w & ~(mask << sh)) | ((d & mask) << sh); lat = 4; end
            else begin eWr = d & mask; lat = 2; end
            refWrite(a, eWr);
        end
    endtask

    task automatic runReq(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] gotData, output logic [31:0] gotWr);
        int lat, tmo, respCnt, respK, wrCnt, wrK;
        logic [31:0] eData, eWr, wrA;
        logic [3:0] wrSel;
        logic eErr, eDoWr, gotErr, leak, readyAfter;
        respCnt = 0; respK = 0; wrCnt = 0; wrK = 0; wrA = 0; wrSel = 0;
        gotData = 0; gotWr = 0; gotErr = 0; leak = 0; readyAfter = 0;
        modelReq(st, f3, a, d, lat, eData, eErr, eDoWr, eWr);
        @(negedge clk);
        reqValid = 1'b1; reqStore = st; reqFunct3 = f3; reqAddr = a; reqData = d;
        tmo = 0;
        while (!reqReady && tmo < 20) begin @(negedge clk); tmo++; end
        check({tag, " reqReady"}, reqReady, 1);
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqStore = 1'($urandom_range(0, 1)); reqFunct3 = 3'($urandom_range(0, 7));
        reqAddr = $urandom; reqData = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (respValid) begin
                respCnt++; respK = k; gotData = respData; gotErr = respError;
            end else if (respData !== 32'b0 || respError !== 1'b0) leak = 1'b1;
            if (memWriteEnable) begin
                wrCnt++; wrK = k; wrA = memAddress; gotWr = memDataIn; wrSel = memWriteByteSelect;
            end
            if (k == lat + 1) readyAfter = reqReady;
        end
        check({tag, " respCount"}, respCnt, 1);
        check({tag, " respCycle"}, respK, lat);
        check({tag, " respData"}, gotData, eData);
        check({tag, " respError"}, gotErr, eErr);
        check({tag, " idleLeak"}, leak, 0);
        check({tag, " readyAgain"}, readyAfter, 1);
        check({tag, " writeCount"}, wrCnt, eDoWr ? 1 : 0);
        if (eDoWr) begin
            check({tag, " writeCycle"}, wrK, lat - 1);
            check({tag, " writeAddr"}, wrA, {a[31:2], 2'b00});
            check({tag, " writeData"}, gotWr, eWr);
            check({tag, " byteSel"}, wrSel, 4'hF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd, gw, v, a, snap;
        logic [2:0] f3;
        logic st;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        check("rst reqReady", reqReady, 0);
        check("rst respValid", respValid, 0);
        check("rst respError", respError, 0);
        check("rst memWriteEnable", memWriteEnable, 0);
        check("rst respData", respData, 0);
        check("rst memDataIn", memDataIn, 0);
        check("rst memAddress", memAddress, 0);
        check("rst byteSel", memWriteByteSelect, 0);

        @(negedge clk);
        preEn = 1'b1;
        for (int i = 0; i < 1088; i++) begin
            v = $urandom;
            if (i == 4) v = 32'h8899_AABB;
            if (i == 1024 + 4) v = 32'h0000_00F0;
            preIdx = 11'(i); preVal = v;
            if (i < 1024) refRam[i] = v;
            else          refOther[i - 1024] = v;
            @(negedge clk);
        end
        preEn = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        check("release reqReady", reqReady, 1);

        runReq("LB", 1'b0, 3'b000, 32'h8000_0011, 32'h0, gd, gw);
        check("LB const", gd, 32'hFFFF_FFAA);
        runReq("LBU", 1'b0, 3'b100, 32'h8000_0011, 32'h0, gd, gw);
        check("LBU const", gd, 32'h0000_00AA);
        runReq("SB", 1'b1, 3'b000, 32'h8000_0012, 32'h1234_5677, gd, gw);
        check("SB const", gw, 32'h8877_AABB);

        // Reset during RD_WAIT of an in-window byte store.
        snap = wrTotal;
        @(negedge clk);
        reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'b000; reqAddr = 32'h8000_0013; reqData = 32'hFF;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check("abort reqReady", reqReady, 0);
        check("abort respValid", respValid, 0);
        check("abort memWriteEnable", memWriteEnable, 0);
        check("abort memAddress", memAddress, 0);
        check("abort memDataIn", memDataIn, 0);
        check("abort byteSel", memWriteByteSelect, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort quiet", {respValid, memWriteEnable}, 2'b00);
        end
        rstN = 1'b1;
        @(negedge clk);
        check("abort readyAfter", reqReady, 1);
        check("abort noWrite", wrTotal, snap);
        check("abort noResp", respValid, 0);
        runReq("LW after abort", 1'b0, 3'b010, 32'h8000_0010, 32'h0, gd, gw);
        check("LW after abort const", gd, 32'h8877_AABB);

        runReq("SW", 1'b1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF, gd, gw);
        runReq("LW", 1'b0, 3'b010, 32'h8000_0020, 32'h0, gd, gw);
        check("LW const", gd, 32'hDEAD_BEEF);
        runReq("LW misaligned", 1'b0, 3'b010, 32'h8000_0002, 32'h0, gd, gw);
        runReq("SH misaligned", 1'b1, 3'b001, 32'h8000_0001, 32'h1111, gd, gw);
        runReq("illegal f3", 1'b0, 3'b011, 32'h8000_0000, 32'h0, gd, gw);
        runReq("store f3 BU", 1'b1, 3'b100, 32'h8000_0000, 32'h0, gd, gw);
        runReq("MMIO SH", 1'b1, 3'b001, 32'h0010_0014, 32'h0000_A5A5, gd, gw);
        check("MMIO SH const", gw, 32'h0000_A5A5);
        runReq("MMIO LW", 1'b0, 3'b010, 32'h0010_0010, 32'h0, gd, gw);
        check("MMIO LW const", gd, 32'h0000_00F0);
        runReq("SB top byte", 1'b1, 3'b000, BASE + 32'd4095, 32'hABCD_EF5A, gd, gw);
        runReq("SB past window", 1'b1, 3'b000, BASE + 32'd4096, 32'h1234_5677, gd, gw);
        check("SB past window const", gw, 32'h0000_0077);
        runReq("SH below window", 1'b1, 3'b001, BASE - 32'd2, 32'hFFFF_8001, gd, gw);
        runReq("LH top half", 1'b0, 3'b001, BASE + 32'd4094, 32'h0, gd, gw);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = BASE + 32'($urandom_range(0, 4095));
                6, 7:             a = 32'h0010_0000 + 32'($urandom_range(0, 255));
                8:                a = BASE + 32'd4096 - 32'($urandom_range(1, 8));
                default:          a = ($urandom_range(0, 1) == 1) ? BASE + 32'd4096 + 32'($urandom_range(0, 7))
                                                                  : BASE - 32'd8 + 32'($urandom_range(0, 7));
            endcase
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
            runReq($sformatf("rand%0d", n), st, f3, a, $urandom, gd, gw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data-memory/MMIO bus: accepts one load or store request at a time from the execute stage and drives `memAddress`, `memWriteEnable`, `memWriteByteSelect` and `memDataIn`, then samples `memDataOut`. The memory returns read data one clock after the address. It does not merge sub-word writes into the stored word, so this unit performs byte/halfword stores as read-modify-write of the full word. Loads are extracted, sign- or zero-extended and returned on a single-cycle response pulse.

## Interface
- `MEM_BASE`, 32'h80000000, byte base of the RAM window
- `MEM_BYTES`, 4096, size of the RAM window in bytes

Ports:
- `clk` in 1: single clock, rising edge
- `rstN` in 1: asynchronous, active-low reset
- `reqValid` in 1: request present
- `reqReady` out 1: unit can accept a request
- `reqStore` in 1: 1 = store, 0 = load
- `reqFunct3` in 3: RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `reqAddr` in 32: byte address
- `reqData` in 32: store data, right-aligned
- `respValid` out 1: one-cycle completion pulse
- `respData` out 32: extended load data; 0 for stores and errors
- `respError` out 1: misaligned access or illegal funct3
- `memAddress` out 32: word address, `{addrQ[31:2],2'b00}`
- `memWriteEnable` out 1: write strobe
- `memWriteByteSelect` out 4: always 4'b1111 whenever `memWriteEnable`=1
- `memDataIn` out 32: full write word
- `memDataOut` in 32: read data, valid one cycle after the address is presented

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- `reqReady` = (state==IDLE). Acceptance is `reqValid&reqReady`.
- On acceptance, latch `addrQ`, `funct3Q`, `storeQ` and `dataQ`, then branch:
  - Illegal funct3 (011, 110, 111), store with funct3 100/101, H with `addr[0]`=1, or W with `addr[1:0]`≠0: go to RESP with `respError`=1. No memory access occurs.
  - W store: go to WR.
  - Any load: go to RD_ISSUE.
  - B/H store inside `[MEM_BASE, MEM_BASE+MEM_BYTES)`: go to RD_ISSUE.
  - B/H store outside the window (MMIO): go to WR with no merge. `memDataIn` = `dataQ` masked to the access width, in lane 0.
- RD_ISSUE: present `memAddress`, with `memWriteEnable`=0. Next state is RD_WAIT.
- RD_WAIT: capture `memDataOut` into `rdWord`.
  - Load: go to RESP.
  - Store: go to WR.
- Load extraction: select the byte lane by `addrQ[1:0]` or the half lane by `addrQ[1]`. B/H are sign-extended from bit 7/15; BU/HU are zero-extended. W passes through.
- Merge for B/H stores inside the window: `rdWord` with the addressed lane replaced by `dataQ[7:0]` or `dataQ[15:0]`. Other bytes are unchanged.
- WR: `memWriteEnable`=1 for exactly one cycle, with `memDataIn` = merged word, or `dataQ` for W. Next state is RESP.
- RESP: `respValid`=1 for one cycle, then IDLE.
- `memAddress` holds `{addrQ[31:2],2'b00}` from acceptance until return to IDLE. It holds its last value in IDLE.

## Timing
- Reset (`rstN`=0, async) forces all of the following regardless of the clock:
  - state = IDLE
  - `reqReady`, `respValid`, `respError` and `memWriteEnable` = 0
  - `respData`, `memDataIn` and `memAddress` = 0
  - `memWriteByteSelect` = 4'b0000
  - `reqReady` rises in the first cycle after `rstN` deasserts.
- Accept at edge T. `respValid` is high during cycle:
  - load: T+3
  - W store or MMIO sub-word store: T+2 (write during T+1)
  - in-window B/H store: T+4 (write during T+3)
  - error: T+1
- Next acceptance is possible at the edge ending the RESP cycle's successor, i.e. one IDLE cycle minimum between requests.
- `reqValid` is ignored outside IDLE. The core must hold its request until `reqReady`.
- Reset mid-operation aborts the access:
  - no write pulse after `rstN` falls
  - no `respValid`
  - latched request is discarded.
- `respData` and `respError` are valid only while `respValid`=1 and are 0 otherwise.

## Test plan
- LB: RAM word at 0x80000010 = 0x8899AABB, load 000 at 0x80000011 → `respData`=0xFFFFFFAA at T+3. LBU at the same address → 0x000000AA.
- SB: same word, store 0x12345677 with funct3 000 at 0x80000012 → single write of 0x8877AABB with byte select 1111 at T+3, `respValid` at T+4.
- SW: store 0xDEADBEEF at 0x80000020 → write at T+1, `respValid` at T+2; a follow-up LW returns 0xDEADBEEF.
- Misaligned: LW at 0x80000002, or SH at 0x80000001 → `respError`=1 at T+1, `memWriteEnable` never asserted.
- MMIO: SH 0x0000A5A5 at 0x00100014 → no read phase, write 0x0000A5A5 at T+1. LW at 0x00100010 with switches 0x00F0 → `respData`=0x000000F0.
- Reset: assert `rstN`=0 during RD_WAIT of an SB → outputs go to reset values immediately, no write, no `respValid`. `reqReady`=1 one cycle after release.
